// File: rtl/trig_pulse_gen_pkg.sv
// trig_pulse_gen_pkg: shared WR timestamp type, FSM states and target arithmetic.
package trig_pulse_gen_pkg;
   localparam int c_TAI_W = 40;
   localparam int c_CYC_W = 28;
   typedef struct packed {
      logic [c_TAI_W-1:0] tai;
      logic [c_CYC_W-1:0] cycles;
   } t_wr_timestamp;
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_PULSE} t_tpg_state;
   function automatic t_wr_timestamp f_add_delay(input t_wr_timestamp ts, input int unsigned delay, input int unsigned modulus);
      logic [c_CYC_W:0] w_sum;
      logic             w_wrap;
      w_sum  = {1'b0, ts.cycles} + (c_CYC_W+1)'(delay);
      w_wrap = w_sum >= (c_CYC_W+1)'(modulus);
      return '{tai: ts.tai + c_TAI_W'(w_wrap), cycles: c_CYC_W'(w_wrap ? w_sum - (c_CYC_W+1)'(modulus) : w_sum)};
   endfunction
endpackage

// File: rtl/trig_pulse_gen_if.sv
// trig_pulse_gen_if: received-timestamp valid/ready stream from the RX streamer.
interface trig_pulse_gen_if;
   import trig_pulse_gen_pkg::*;
   logic               rx_valid_i;
   logic               rx_ready_o;
   logic [c_TAI_W-1:0] rx_tai_i;
   logic [c_CYC_W-1:0] rx_cycles_i;
   modport master (output rx_valid_i, rx_tai_i, rx_cycles_i, input rx_ready_o);
   modport slave (input rx_valid_i, rx_tai_i, rx_cycles_i, output rx_ready_o);
endinterface

// File: rtl/trig_ts_fifo.sv
// trig_ts_fifo: synchronous FIFO of WR timestamps with flush and occupancy count.
module trig_ts_fifo
   import trig_pulse_gen_pkg::*;
#(
   parameter int unsigned g_depth = 8
) (
   input  logic                     clk_sys_i,
   input  logic                     rst_sys_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  t_wr_timestamp            din_i,
   output t_wr_timestamp            dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(g_depth):0] count_o
);
   localparam int c_AW = $clog2(g_depth);
   t_wr_timestamp   r_mem [g_depth];
   logic [c_AW-1:0] r_wr, r_rd;
   logic [c_AW:0]   r_cnt;
   logic            w_push, w_pop;
   assign full_o  = r_cnt == (c_AW+1)'(g_depth);
   assign empty_o = r_cnt == '0;
   assign w_pop   = pop_i && !empty_o;
   // a pop frees the slot being read, so a push into a full FIFO may proceed alongside it
   assign w_push  = push_i && (!full_o || w_pop);
   assign dout_o  = r_mem[r_rd];
   assign count_o = r_cnt;
   always_ff @(posedge clk_sys_i)
      if (w_push) r_mem[r_wr] <= din_i;
   always_ff @(posedge clk_sys_i)
      if (rst_sys_i || flush_i) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         r_wr  <= r_wr + c_AW'(w_push);
         r_rd  <= r_rd + c_AW'(w_pop);
         r_cnt <= r_cnt + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
      end
endmodule

// File: rtl/trig_pulse_gen.sv
// trig_pulse_gen: regenerates a trigger pulse at received timestamp + fixed delay in local WR time.
// Define TRIG_PULSE_GEN_STATS_EN to build the saturating fired/late/overflow counters.
module trig_pulse_gen
   import trig_pulse_gen_pkg::*;
#(
   parameter int unsigned g_delay_cycles   = 2500,
   parameter int unsigned g_pulse_width    = 125,
   parameter int unsigned g_fifo_depth     = 8,
   parameter int unsigned g_cycles_per_sec = 125000000
) (
   input  logic               clk_sys_i,
   input  logic               rst_sys_i,
   trig_pulse_gen_if.slave    rx,
   input  logic               tm_time_valid_i,
   input  logic [c_TAI_W-1:0] tm_tai_i,
   input  logic [c_CYC_W-1:0] tm_cycles_i,
   output logic               pulse_o,
   output logic               late_o,
   output logic               overflow_o,
   output logic [15:0]        cnt_fired_o,
   output logic [15:0]        cnt_late_o,
   output logic [15:0]        cnt_ovf_o
);
   localparam int c_AW = $clog2(g_fifo_depth);
   t_wr_timestamp w_now, w_head, r_pipe_ts, r_target;
   t_tpg_state    r_state, w_next;
   logic          r_pipe_valid, w_full, w_empty, w_afull, w_accept, w_ovf;
   logic          w_pop, w_late, r_late, r_ovf;
   logic [c_AW:0] w_count;
   logic [15:0]   r_width;
   assign w_now = '{tai: tm_tai_i, cycles: tm_cycles_i};
   // the word sitting in the pipeline register already owns a FIFO slot
   assign w_afull       = w_full || (r_pipe_valid && w_count == (c_AW+1)'(g_fifo_depth - 1));
   assign rx.rx_ready_o = tm_time_valid_i && !rst_sys_i && !w_afull;
   assign w_accept      = rx.rx_valid_i && rx.rx_ready_o;
   assign w_ovf         = rx.rx_valid_i && tm_time_valid_i && w_afull;
   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i || !tm_time_valid_i) r_pipe_valid <= 1'b0;
      else r_pipe_valid <= w_accept;
      if (w_accept) r_pipe_ts <= f_add_delay('{tai: rx.rx_tai_i, cycles: rx.rx_cycles_i}, g_delay_cycles, g_cycles_per_sec);
   end
   trig_ts_fifo #(.g_depth(g_fifo_depth)) u_fifo (
      .clk_sys_i(clk_sys_i),
      .rst_sys_i(rst_sys_i),
      .flush_i  (!tm_time_valid_i),
      .push_i   (r_pipe_valid),
      .pop_i    (w_pop),
      .din_i    (r_pipe_ts),
      .dout_o   (w_head),
      .full_o   (w_full),
      .empty_o  (w_empty),
      .count_o  (w_count)
   );
   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      w_late = 1'b0;
      case (r_state)
         S_IDLE:  w_next = w_empty ? S_IDLE : S_ARM;
         S_ARM: begin
            w_pop  = 1'b1;
            w_late = w_head <= w_now;
            w_next = w_late ? S_IDLE : S_WAIT;
         end
         S_WAIT:  w_next = (r_target == w_now) ? S_PULSE : S_WAIT;
         default: w_next = (r_width == 16'(g_pulse_width - 1)) ? S_IDLE : S_PULSE;
      endcase
      if (!tm_time_valid_i) begin
         w_next = S_IDLE;
         w_pop  = 1'b0;
         w_late = 1'b0;
      end
   end
   always_ff @(posedge clk_sys_i)
      if (rst_sys_i) begin
         r_state <= S_IDLE;
         r_width <= '0;
         r_late  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_width <= (r_state == S_PULSE && w_next == S_PULSE) ? r_width + 16'd1 : '0;
         r_late  <= w_late;
         r_ovf   <= w_ovf;
         if (r_state == S_ARM) r_target <= w_head;
      end
   assign pulse_o    = r_state == S_PULSE;
   assign late_o     = r_late;
   assign overflow_o = r_ovf;
`ifdef TRIG_PULSE_GEN_STATS_EN
   logic [15:0] r_cnt_fired, r_cnt_late, r_cnt_ovf;
   always_ff @(posedge clk_sys_i)
      if (rst_sys_i) begin
         r_cnt_fired <= '0;
         r_cnt_late  <= '0;
         r_cnt_ovf   <= '0;
      end else begin
         if (r_state == S_WAIT && w_next == S_PULSE && r_cnt_fired != '1) r_cnt_fired <= r_cnt_fired + 16'd1;
         if (w_late && r_cnt_late != '1) r_cnt_late <= r_cnt_late + 16'd1;
         if (w_ovf && r_cnt_ovf != '1) r_cnt_ovf <= r_cnt_ovf + 16'd1;
      end
   assign cnt_fired_o = r_cnt_fired;
   assign cnt_late_o  = r_cnt_late;
   assign cnt_ovf_o   = r_cnt_ovf;
`else
   assign cnt_fired_o = '0;
   assign cnt_late_o  = '0;
   assign cnt_ovf_o   = '0;
`endif
endmodule

// File: doc/trig_pulse_gen.md
TRIG_PULSE_GEN -- requirements
Module: trig_pulse_gen

Interface
REQ-001 SHALL have parameter g_delay_cycles, default 2500, fixed delay added to each received timestamp (20 us at 8 ns).
REQ-002 SHALL have parameter g_pulse_width, default 125, pulse_o high time in clk_sys_i cycles; legal range 1..2^16-1.
REQ-003 SHALL have parameter g_fifo_depth, default 8, pending-target capacity; power of two, 2..64.
REQ-004 SHALL have parameter g_cycles_per_sec, default 125000000, cycle-counter modulus.
REQ-005 SHALL have port clk_sys_i, input, 1, system clock; all logic in this single domain.
REQ-006 SHALL have port rst_sys_i, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have ports rx_valid_i (input, 1), rx_ready_o (output, 1), rx_tai_i (input, 40), rx_cycles_i (input, 28): received-timestamp valid/ready stream from the RX streamer.
REQ-008 SHALL have ports tm_time_valid_i (input, 1), tm_tai_i (input, 40), tm_cycles_i (input, 28): local WR time.
REQ-009 SHALL have port pulse_o, output, 1, regenerated trigger.
REQ-010 SHALL have ports late_o (output, 1) and overflow_o (output, 1): single-cycle event strobes.
REQ-011 SHALL have ports cnt_fired_o, cnt_late_o, cnt_ovf_o, each output, 16: statistics counters.

Function
REQ-012 SHALL accept a timestamp on a cycle with rx_valid_i=1 and rx_ready_o=1; rx_ready_o=1 when FIFO not full and tm_time_valid_i=1.
REQ-013 SHALL compute target: cycles=rx_cycles_i+g_delay_cycles; if >=g_cycles_per_sec, subtract g_cycles_per_sec and tai=rx_tai_i+1, else tai=rx_tai_i; 29-bit intermediate, no truncation.
REQ-014 SHALL register the target one cycle after acceptance and write it to the FIFO on the following edge (2-cycle accept-to-FIFO latency).
REQ-015 SHALL assert overflow_o for one cycle when rx_valid_i=1, FIFO full, tm_time_valid_i=1; the word is dropped, not retried.
REQ-016 SHALL implement FSM IDLE, ARM, WAIT, PULSE.
REQ-017 IDLE->ARM when FIFO non-empty; ARM pops head into target register (1 cycle).
REQ-018 ARM->WAIT when target strictly later than local time; ARM->IDLE with late_o=1 for one cycle when target <= local time.
REQ-019 WAIT->PULSE when {tm_tai_i,tm_cycles_i} equals target; pulse_o rises on the next edge.
REQ-020 PULSE holds pulse_o=1 exactly g_pulse_width cycles, then ->IDLE; targets maturing meanwhile are evaluated afterwards and dropped as late by REQ-018.
REQ-021 Comparison SHALL be 68-bit unsigned on {tai,cycles}.
REQ-022 When tm_time_valid_i=0: FIFO flushed, pipeline register cleared, FSM->IDLE, pulse_o=0 next cycle, even mid-PULSE.
REQ-023 Simultaneous FIFO push and pop SHALL both succeed, occupancy unchanged.

Reset
REQ-024 On rst_sys_i=1 at a clock edge: FSM=IDLE, FIFO empty, pipeline invalid, pulse_o=0, late_o=0, overflow_o=0, rx_ready_o=0, counters=0.
REQ-025 Reset mid-PULSE SHALL drop pulse_o to 0 on that edge; no residual pulse after release.

Configuration
REQ-026 Macro TRIG_PULSE_GEN_STATS_EN defined: cnt_fired_o/cnt_late_o/cnt_ovf_o count pulses started, late drops, overflow drops; saturate at 16'hFFFF; cleared only by reset.
REQ-027 Macro undefined: counter outputs constant 0, no counter logic synthesised; all other behaviour identical.

Structure
REQ-028 Package trig_pulse_gen_pkg SHALL hold: t_wr_timestamp struct (tai 40, cycles 28), t_tpg_state enum, c_TAI_W=40, c_CYC_W=28.
REQ-029 Sub-module trig_ts_fifo SHALL be a synchronous FIFO of t_wr_timestamp with full/empty, flush and synchronous active-high reset.

Verification
REQ-030 Time valid, ts (tai=5, cycles=1000) -> pulse_o high at local (5, 3500)+1 cycle for 125 cycles; cnt_fired_o=1.
REQ-031 ts (5, 124999000) -> target (6, 1500) wrap; pulse fires at (6, 1500)+1.
REQ-032 ts whose target is already past (local (10,0), ts (9,0)) -> late_o one cycle, no pulse, cnt_late_o=1.
REQ-033 9 back-to-back ts with depth 8, FSM in WAIT -> FIFO absorbs 8; 9th rejected or, if forced with rx_ready_o ignored, overflow_o once, cnt_ovf_o=1.
REQ-034 tm_time_valid_i dropped mid-PULSE with 3 queued -> pulse_o low next cycle, FIFO empty, no pulses after valid returns.
REQ-035 Two targets 50 cycles apart with g_pulse_width=125 -> first fires, second reported late.
